vga_rx_monitor: RTL and testbench



---
 rtl/vga_rx_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: locks to hs/vs, recovers column/row, checks sync timing and
// blanking, and reports a per-frame pixel checksum plus a captured probe pixel.
module vga_rx_monitor #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    input  logic [9:0]  probe_x,
    input  logic [8:0]  probe_y,
    input  logic        clr_err,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  col,
    output logic [8:0]  row,
    output logic [11:0] pix,
    output logic [15:0] frame_sum,
    output logic        sum_valid,
    output logic [15:0] frame_count,
    output logic [11:0] probe_pix,
    output logic [2:0]  err
);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_OVER      = 10'(H_TOTAL);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

    state_t      state_reg;
    logic        hs_d1_reg, hs_d2_reg, vs_d1_reg, vs_d2_reg;
    logic [11:0] rgb_d1_reg, rgb_d2_reg;
    logic [9:0]  h_cnt_reg, v_cnt_reg;
    logic [15:0] acc_reg;
    logic        frame_err_reg;
    logic [2:0]  err_reg, err_next, err_new;

    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       visible, checks_on, hs_bad, vs_bad, blank_bad;
    logic       timing_bad, frame_bad, probe_hit;
    logic [9:0] col_now;
    logic [8:0] row_now;

    // Stage 1 samples the pins; stage 2 is the edge reference and holds the pixel
    // that h_cnt/v_cnt currently describe.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_d1_reg  <= 1'b1;
            hs_d2_reg  <= 1'b1;
            vs_d1_reg  <= 1'b1;
            vs_d2_reg  <= 1'b1;
            rgb_d1_reg <= 12'h000;
            rgb_d2_reg <= 12'h000;
        end else begin
            hs_d1_reg  <= hs;
            hs_d2_reg  <= hs_d1_reg;
            vs_d1_reg  <= vs;
            vs_d2_reg  <= vs_d1_reg;
            rgb_d1_reg <= {b, g, r};
            rgb_d2_reg <= rgb_d1_reg;
        end
    end

    assign hs_fall = hs_d2_reg & ~hs_d1_reg;
    assign hs_rise = ~hs_d2_reg & hs_d1_reg;
    assign vs_fall = vs_d2_reg & ~vs_d1_reg;
    assign vs_rise = ~vs_d2_reg & vs_d1_reg;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt_reg <= 10'd0;
            v_cnt_reg <= 10'd0;
        end else begin
            h_cnt_reg <= hs_fall ? 10'd0 : h_cnt_reg + 10'd1;
            if (vs_fall)
                v_cnt_reg <= 10'd0;
            else if (hs_fall)
                v_cnt_reg <= v_cnt_reg + 10'd1;
        end
    end

    assign visible = (h_cnt_reg >= H_START) && (h_cnt_reg < H_END) &&
                     (v_cnt_reg >= V_START) && (v_cnt_reg < V_END);
    assign col_now = h_cnt_reg - H_START;
    assign row_now = 9'(v_cnt_reg - V_START);

    assign checks_on = (state_reg != S_SEARCH);
    // The overflow term fires once, exactly when the count steps past the last column.
    assign hs_bad = (hs_fall && (h_cnt_reg != H_LAST)) ||
                    (hs_rise && (h_cnt_reg != H_SYNC_LAST)) ||
                    (!hs_fall && (h_cnt_reg == H_OVER));
    assign vs_bad = (vs_fall && (v_cnt_reg != V_LAST)) ||
                    (vs_rise && (v_cnt_reg != V_SYNC_LAST)) ||
                    ((vs_fall || vs_rise) && !hs_fall);
    assign blank_bad = (state_reg == S_LOCKED) && !visible && (rgb_d2_reg != 12'h000);

    assign err_new    = {blank_bad, vs_bad & checks_on, hs_bad & checks_on};
    assign timing_bad = |err_new[1:0];
    assign frame_bad  = |err_new;
    assign probe_hit  = (state_reg == S_LOCKED) && visible &&
                        (col_now == probe_x) && (row_now == probe_y);

    // A new error outranks a simultaneous clear.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_err
            assign err_next[gi] = err_new[gi] | (err_reg[gi] & ~clr_err);
        end
    endgenerate

    always_ff @(posedge vga_clk) begin
        if (rst)
            err_reg <= 3'b000;
        else
            err_reg <= err_next;
    end
    assign err = err_reg;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_reg     <= S_SEARCH;
            locked        <= 1'b0;
            frame_err_reg <= 1'b0;
            acc_reg       <= 16'h0000;
            frame_sum     <= 16'h0000;
            sum_valid     <= 1'b0;
            frame_count   <= 16'h0000;
            probe_pix     <= 12'h000;
        end else begin
            sum_valid <= 1'b0;
            if (visible)
                acc_reg <= acc_reg + {4'h0, rgb_d2_reg};
            if (frame_bad)
                frame_err_reg <= 1'b1;
            if (probe_hit)
                probe_pix <= rgb_d2_reg;
            if (vs_fall) begin
                acc_reg       <= 16'h0000;
                frame_err_reg <= 1'b0;
                if (state_reg != S_SEARCH) begin
                    frame_sum <= acc_reg;
                    sum_valid <= 1'b1;
                end
                if ((state_reg == S_LOCKED) && !frame_err_reg && !frame_bad)
                    frame_count <= frame_count + 16'd1;
            end
            case (state_reg)
                S_SEARCH: begin
                    if (vs_fall)
                        state_reg <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (vs_fall && !frame_err_reg && !frame_bad) begin
                        state_reg <= S_LOCKED;
                        locked    <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (timing_bad) begin
                        state_reg <= S_SEARCH;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_SEARCH;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            col       <= 10'd0;
            row       <= 9'd0;
            pix       <= 12'h000;
        end else begin
            pix_valid <= visible;
            if (visible) begin
                col <= col_now;
                row <= row_now;
                pix <= rgb_d2_reg;
            end
        end
    end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced 32x16 raster (16x8 visible) so many
// frames fit in a short run.
module tb_vga_rx_monitor;
    localparam int HS = 4, HB = 4, HA = 16, HT = 32;
    localparam int VS = 2, VB = 3, VA = 8, VT = 16;
    localparam int H0 = HS + HB, H1 = HS + HB + HA;
    localparam int V0 = VS + VB, V1 = VS + VB + VA;

    logic        vga_clk = 1'b0;
    logic        rst, hs, vs, clr_err;
    logic [3:0]  r, g, b;
    logic [9:0]  probe_x;
    logic [8:0]  probe_y;
    logic        locked, pix_valid, sum_valid;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [11:0] pix, probe_pix;
    logic [15:0] frame_sum, frame_count;
    logic [2:0]  err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int sv_count = 0;
    int drop_cyc = -1;
    int fall_cyc = 0;
    int lat_bad = 0;
    int sv_base = 0;
    logic [15:0] last_sum = 16'h0;
    logic        locked_prev = 1'b0;
    bit          hv[3];
    int          hc[3], hr[3];
    logic [11:0] hval[3];

    vga_rx_monitor #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .vga_clk(vga_clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .probe_x(probe_x), .probe_y(probe_y), .clr_err(clr_err),
        .locked(locked), .pix_valid(pix_valid), .col(col), .row(row), .pix(pix),
        .frame_sum(frame_sum), .sum_valid(sum_valid), .frame_count(frame_count),
        .probe_pix(probe_pix), .err(err)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    always @(negedge vga_clk) begin
        if (sum_valid === 1'b1) begin
            sv_count <= sv_count + 1;
            last_sum <= frame_sum;
        end
        if (locked_prev === 1'b1 && locked === 1'b0)
            drop_cyc <= cyc;
        locked_prev <= locked;
    end

    // mode 0: constant 00F, mode 1: pixel = 16*row + col, mode 2: constant plus FFF in
    // the front porch of line 5. Optionally checks every output pixel 3 drive slots later.
    task automatic drive_frame(input int mode, input int vs_lines, input int short_line,
                               input bit clr, input bit chk, input int first_line,
                               input int last_line);
        for (int v = first_line; v <= last_line; v++) begin
            int period;
            period = (v == short_line) ? HT - 1 : HT;
            for (int h = 0; h < period; h++) begin
                bit vis;
                logic [11:0] val;
                @(negedge vga_clk);
                if (chk) begin
                    if (hv[2]) begin
                        if (pix_valid !== 1'b1 || col !== 10'(hc[2]) || row !== 9'(hr[2]) ||
                            pix !== hval[2])
                            lat_bad++;
                    end else if (pix_valid !== 1'b0) begin
                        lat_bad++;
                    end
                end
                vis = (h >= H0) && (h < H1) && (v >= V0) && (v < V1);
                val = 12'h000;
                if (vis)
                    val = (mode == 1) ? 12'(16 * (v - V0) + (h - H0)) : 12'h00F;
                else if (mode == 2 && v == 5 && h >= H1)
                    val = 12'hFFF;
                if (short_line >= 0 && v == short_line + 1 && h == 0)
                    fall_cyc = cyc;
                for (int k = 2; k > 0; k--) begin
                    hv[k] = hv[k-1]; hc[k] = hc[k-1]; hr[k] = hr[k-1]; hval[k] = hval[k-1];
                end
                hv[0] = vis; hc[0] = h - H0; hr[0] = v - V0; hval[0] = val;
                clr_err = clr && (v == first_line) && (h == 0);
                hs = (h >= HS);
                vs = (v >= vs_lines);
                r = val[3:0];
                g = val[7:4];
                b = val[11:8];
            end
        end
    endtask

    task automatic full(input int mode, input int vs_lines, input int short_line,
                        input bit clr, input bit chk);
        drive_frame(mode, vs_lines, short_line, clr, chk, 0, VT - 1);
    endtask

    task automatic test_reset;
        rst = 1'b1; hs = 1'b1; vs = 1'b1; r = 4'h0; g = 4'h0; b = 4'h0;
        clr_err = 1'b0; probe_x = 10'd0; probe_y = 9'd0;
        repeat (4) @(negedge vga_clk);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
        n_checks++; if (col !== 10'd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", col); end
        n_checks++; if (row !== 9'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", row); end
        n_checks++; if (pix !== 12'h000) begin n_fail++; $display("FAIL reset_pix: got %h want 000", pix); end
        n_checks++; if (frame_sum !== 16'h0) begin n_fail++; $display("FAIL reset_frame_sum: got %h want 0000", frame_sum); end
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
        n_checks++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_checks++; if (probe_pix !== 12'h000) begin n_fail++; $display("FAIL reset_probe_pix: got %h want 000", probe_pix); end
        n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", err); end
        $display("reset: outputs checked");
        rst = 1'b0;
    endtask

    task automatic test_lock;
        full(0, VS, -1, 0, 0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_f1_locked: got %b want 0", locked); end
        n_checks++; if (sv_count !== 0) begin n_fail++; $display("FAIL lock_f1_sum_pulses: got %0d want 0", sv_count); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_f2_locked: got %b want 1", locked); end
        n_checks++; if (sv_count !== 1) begin n_fail++; $display("FAIL lock_f2_sum_pulses: got %0d want 1", sv_count); end
        n_checks++; if (last_sum !== 16'h0780) begin n_fail++; $display("FAIL lock_f2_sum: got %h want 0780", last_sum); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL lock_f2_count: got %0d want 0", frame_count); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL lock_f3_count: got %0d want 1", frame_count); end
        n_checks++; if (sv_count !== 2) begin n_fail++; $display("FAIL lock_f3_sum_pulses: got %0d want 2", sv_count); end
        n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL lock_f3_err: got %b want 000", err); end
        $display("lock: locked=%b frame_count=%0d frame_sum=%h", locked, frame_count, last_sum);
    endtask

    task automatic test_gradient;
        probe_x = 10'd5; probe_y = 9'd2; lat_bad = 0;
        full(1, VS, -1, 0, 1);
        n_checks++; if (lat_bad !== 0) begin n_fail++; $display("FAIL grad_f4_pixel_stream: got %0d bad pixels want 0", lat_bad); end
        n_checks++; if (probe_pix !== 12'h025) begin n_fail++; $display("FAIL grad_probe_5_2: got %h want 025", probe_pix); end
        n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL grad_f4_count: got %0d want 2", frame_count); end
        probe_x = 10'd15; probe_y = 9'd7; lat_bad = 0;
        full(1, VS, -1, 0, 1);
        n_checks++; if (lat_bad !== 0) begin n_fail++; $display("FAIL grad_f5_pixel_stream: got %0d bad pixels want 0", lat_bad); end
        n_checks++; if (probe_pix !== 12'h07F) begin n_fail++; $display("FAIL grad_probe_15_7: got %h want 07F", probe_pix); end
        n_checks++; if (last_sum !== 16'h1FC0) begin n_fail++; $display("FAIL grad_f4_sum: got %h want 1FC0", last_sum); end
        probe_x = 10'd20; probe_y = 9'd3;
        full(0, VS, -1, 0, 0);
        n_checks++; if (probe_pix !== 12'h07F) begin n_fail++; $display("FAIL grad_probe_hold: got %h want 07F", probe_pix); end
        n_checks++; if (last_sum !== 16'h1FC0) begin n_fail++; $display("FAIL grad_f5_sum: got %h want 1FC0", last_sum); end
        n_checks++; if (frame_count !== 16'd4) begin n_fail++; $display("FAIL grad_f6_count: got %0d want 4", frame_count); end
        $display("gradient: probe_pix=%h frame_sum=%h", probe_pix, last_sum);
    endtask

    task automatic test_blank;
        full(2, VS, -1, 0, 0);
        n_checks++; if (err !== 3'b100) begin n_fail++; $display("FAIL blank_err: got %b want 100", err); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL blank_locked: got %b want 1", locked); end
        n_checks++; if (frame_count !== 16'd5) begin n_fail++; $display("FAIL blank_f7_count: got %0d want 5", frame_count); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (frame_count !== 16'd5) begin n_fail++; $display("FAIL blank_frame_not_counted: got %0d want 5", frame_count); end
        n_checks++; if (last_sum !== 16'h0780) begin n_fail++; $display("FAIL blank_f7_sum: got %h want 0780", last_sum); end
        full(0, VS, -1, 1, 0);
        n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL blank_clr_err: got %b want 000", err); end
        n_checks++; if (frame_count !== 16'd6) begin n_fail++; $display("FAIL blank_f9_count: got %0d want 6", frame_count); end
        $display("blank: err=%b frame_count=%0d", err, frame_count);
    endtask

    task automatic test_hs_err;
        full(0, VS, 4, 0, 0);
        n_checks++; if (err !== 3'b001) begin n_fail++; $display("FAIL hs_err_flag: got %b want 001", err); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL hs_err_unlock: got %b want 0", locked); end
        n_checks++; if (drop_cyc - fall_cyc < 1 || drop_cyc - fall_cyc > 3) begin n_fail++; $display("FAIL hs_err_drop_delay: got %0d clocks want 1..3", drop_cyc - fall_cyc); end
        n_checks++; if (frame_count !== 16'd7) begin n_fail++; $display("FAIL hs_err_count: got %0d want 7", frame_count); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL hs_relock_early: got %b want 0", locked); end
        n_checks++; if (sv_count !== 9) begin n_fail++; $display("FAIL hs_search_no_pulse: got %0d want 9", sv_count); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hs_relock: got %b want 1", locked); end
        n_checks++; if (sv_count !== 10) begin n_fail++; $display("FAIL hs_measure_pulse: got %0d want 10", sv_count); end
        n_checks++; if (err !== 3'b001) begin n_fail++; $display("FAIL hs_err_sticky: got %b want 001", err); end
        $display("hs_err: err=%b locked=%b drop=%0d clocks", err, locked, drop_cyc - fall_cyc);
    endtask

    task automatic test_vs_err;
        full(0, 3, -1, 0, 0);
        n_checks++; if (err !== 3'b011) begin n_fail++; $display("FAIL vs_err_flag: got %b want 011", err); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL vs_err_unlock: got %b want 0", locked); end
        n_checks++; if (frame_count !== 16'd8) begin n_fail++; $display("FAIL vs_err_count: got %0d want 8", frame_count); end
        full(0, VS, -1, 1, 0);
        n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL vs_clr_err: got %b want 000", err); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL vs_relock: got %b want 1", locked); end
        $display("vs_err: err=%b locked=%b", err, locked);
    endtask

    task automatic test_reset_mid;
        drive_frame(0, VS, -1, 0, 0, 0, 9);
        @(negedge vga_clk);
        rst = 1'b1; hs = 1'b0; vs = 1'b1; r = 4'h0; g = 4'h0; b = 4'h0;
        @(negedge vga_clk);
        rst = 1'b0;
        sv_base = sv_count;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_locked: got %b want 0", locked); end
        n_checks++; if (pix_valid !== 1'b0 || col !== 10'd0 || row !== 9'd0 || pix !== 12'h0) begin n_fail++; $display("FAIL rmid_pixel: got %b/%0d/%0d/%h want 0/0/0/000", pix_valid, col, row, pix); end
        n_checks++; if (frame_sum !== 16'h0 || sum_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_sum: got %h/%b want 0000/0", frame_sum, sum_valid); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", frame_count); end
        n_checks++; if (probe_pix !== 12'h0 || err !== 3'b000) begin n_fail++; $display("FAIL rmid_probe_err: got %h/%b want 000/000", probe_pix, err); end
        drive_frame(0, VS, -1, 0, 0, 11, VT - 1);
        full(1, VS, -1, 0, 0);
        n_checks++; if (sv_count !== sv_base) begin n_fail++; $display("FAIL rmid_no_early_pulse: got %0d pulses want 0", sv_count - sv_base); end
        full(0, VS, -1, 0, 0);
        n_checks++; if (sv_count !== sv_base + 1) begin n_fail++; $display("FAIL rmid_first_pulse: got %0d pulses want 1", sv_count - sv_base); end
        n_checks++; if (last_sum !== 16'h1FC0) begin n_fail++; $display("FAIL rmid_full_frame_sum: got %h want 1FC0", last_sum); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rmid_relock: got %b want 1", locked); end
        $display("reset_mid: first sum after reset=%h", last_sum);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            hv[k] = 1'b0; hc[k] = 0; hr[k] = 0; hval[k] = 12'h000;
        end
        test_reset();
        test_lock();
        test_gradient();
        test_blank();
        test_hs_err();
        test_vs_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
